// File: rtl/serial_reduction_receiver.sv
// Serial parity-checked word receiver: deserialises WIDTH bits LSB first plus a parity bit,
// building AND/OR/XOR reductions per beat. Define SERIAL_REDUCTION_STATS_EN to add err_count.
module serial_reduction_receiver #(
  parameter int WIDTH      = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_bit,
  input  logic             s_first,
  output logic             s_ready,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             and_r,
  output logic             or_r,
  output logic             xor_r,
  output logic             parity_err,
  output logic             frame_err
`ifdef SERIAL_REDUCTION_STATS_EN
  , output logic [7:0]     err_count
`endif
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic          ODD  = (PARITY_ODD != 0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] data_acc;
  logic             and_acc, or_acc, xor_acc;
  logic             accept, restart, abort, parity_bad;

  function automatic logic parity_fail(input logic acc, input logic p);
    return (acc ^ p) != ODD;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    s_ready    = (state != DONE);
    accept     = s_valid && s_ready;
    restart    = accept && s_first;
    abort      = restart && (state == DATA || state == PARITY);
    parity_bad = parity_fail(xor_acc, s_bit);
    case (state)
      IDLE:   if (restart) state_nxt = DATA;
      DATA:   if (accept && !s_first && cnt == LAST) state_nxt = PARITY;
      PARITY: if (accept) state_nxt = s_first ? DATA : DONE;
      DONE:   if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Deserialiser and running reductions; any s_first beat reseeds them as bit 0.
  always_ff @(posedge clk) begin
    if (restart) begin
      data_acc <= {{(WIDTH-1){1'b0}}, s_bit};
      and_acc  <= s_bit;
      or_acc   <= s_bit;
      xor_acc  <= s_bit;
    end else if (accept && state == DATA) begin
      data_acc[cnt] <= s_bit;
      and_acc       <= and_acc & s_bit;
      or_acc        <= or_acc | s_bit;
      xor_acc       <= xor_acc ^ s_bit;
    end
  end

  // Result register: loaded on the parity beat, held until the output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      and_r      <= 1'b0;
      or_r       <= 1'b0;
      xor_r      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= abort;
      if (restart) begin
        cnt <= CW'(1);
      end else if (accept && state == DATA) begin
        cnt <= cnt + CW'(1);
      end else if (accept && state == PARITY) begin
        m_valid    <= 1'b1;
        m_data     <= data_acc;
        and_r      <= and_acc;
        or_r       <= or_acc;
        xor_r      <= xor_acc;
        parity_err <= parity_bad;
      end
      if (state == DONE && m_ready) m_valid <= 1'b0;
    end
  end

`ifdef SERIAL_REDUCTION_STATS_EN
  logic       bad_frame;
  logic [1:0] err_inc;

  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, c} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  always_comb begin
    bad_frame = accept && !s_first && state == PARITY && parity_bad;
    err_inc   = {1'b0, bad_frame} + {1'b0, abort};
  end

  always_ff @(posedge clk) begin
    if (rst) err_count <= '0;
    else     err_count <= sat_add(err_count, err_inc);
  end
`endif

endmodule

// File: tb/tb_serial_reduction_receiver.sv
// Directed plus randomized bench for serial_reduction_receiver; runs an even-parity and an
// odd-parity instance on the same stimulus and checks both against a word-level model.
module tb_serial_reduction_receiver;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, s_valid, s_bit, s_first, m_ready;
  logic         s_ready, m_valid, and_r, or_r, xor_r, parity_err, frame_err;
  logic [W-1:0] m_data;
  logic         u1_s_ready, u1_m_valid, u1_and_r, u1_or_r, u1_xor_r, u1_parity_err, u1_frame_err;
  logic [W-1:0] u1_m_data;
`ifdef SERIAL_REDUCTION_STATS_EN
  logic [7:0]   err_count, u1_err_count;
  int           exp_err0 = 0, exp_err1 = 0;
`endif

  int checks_total  = 0;
  int checks_passed = 0;

  serial_reduction_receiver #(.WIDTH(W), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_bit(s_bit), .s_first(s_first),
    .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .and_r(and_r), .or_r(or_r), .xor_r(xor_r), .parity_err(parity_err), .frame_err(frame_err)
`ifdef SERIAL_REDUCTION_STATS_EN
    , .err_count(err_count)
`endif
  );

  serial_reduction_receiver #(.WIDTH(W), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_bit(s_bit), .s_first(s_first),
    .s_ready(u1_s_ready), .m_valid(u1_m_valid), .m_ready(m_ready), .m_data(u1_m_data),
    .and_r(u1_and_r), .or_r(u1_or_r), .xor_r(u1_xor_r), .parity_err(u1_parity_err),
    .frame_err(u1_frame_err)
`ifdef SERIAL_REDUCTION_STATS_EN
    , .err_count(u1_err_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic note_err(input logic e0, input logic e1);
`ifdef SERIAL_REDUCTION_STATS_EN
    if (e0 && exp_err0 < 255) exp_err0++;
    if (e1 && exp_err1 < 255) exp_err1++;
`endif
  endtask

  task automatic chk_counts(input string tag);
`ifdef SERIAL_REDUCTION_STATS_EN
    chk({tag, "_err_count"}, err_count, exp_err0);
    chk({tag, "_u1_err_count"}, u1_err_count, exp_err1);
`endif
  endtask

  // One beat; waits (bounded) for s_ready, returns 1ns after the accepting edge.
  task automatic beat(input logic first, input logic b);
    int guard = 0;
    s_valid = 1'b1; s_first = first; s_bit = b;
    while (!s_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!s_ready) chk("s_ready_timeout", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_first = 1'b0; s_bit = 1'b0;
  endtask

  task automatic check_result(input logic [W-1:0] w, input logic p);
    logic pe0, pe1;
    pe0 = ((^w) ^ p) != 1'b0;
    pe1 = ((^w) ^ p) != 1'b1;
    chk("m_valid", m_valid, 1);
    chk("m_data", m_data, w);
    chk("and_r", and_r, &w);
    chk("or_r", or_r, |w);
    chk("xor_r", xor_r, ^w);
    chk("parity_err", parity_err, pe0);
    chk("u1_parity_err", u1_parity_err, pe1);
    chk("u1_result", {u1_m_valid, u1_m_data, u1_and_r, u1_or_r, u1_xor_r},
        {1'b1, w, &w, |w, ^w});
    note_err(pe0, pe1);
    chk_counts("frame");
  endtask

  // Full frame; if aborting, the first beat must raise frame_err for exactly one cycle.
  task automatic send_frame(input logic [W-1:0] w, input logic p, input logic aborting);
    for (int i = 0; i < W; i++) begin
      beat(i == 0, w[i]);
      if (i == 0) begin
        chk("frame_err_pulse", {frame_err, u1_frame_err}, {2{aborting}});
        if (aborting) note_err(1'b1, 1'b1);
      end
      if (i == 1) chk("frame_err_clear", {frame_err, u1_frame_err}, 0);
    end
    chk("m_valid_pre", {m_valid, u1_m_valid}, 0);
    beat(1'b0, p);
    check_result(w, p);
  endtask

  task automatic handshake(input int delay, input logic [W-1:0] w);
    for (int d = 0; d < delay; d++) begin
      @(posedge clk); #1;
      chk("hold", {m_valid, s_ready, m_data}, {1'b1, 1'b0, w});
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("hs_m_valid", {m_valid, u1_m_valid}, 0);
    chk("hs_s_ready", {s_ready, u1_s_ready}, 2'b11);
    chk("hs_m_data_kept", m_data, w);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef SERIAL_REDUCTION_STATS_EN
    exp_err0 = 0;
    exp_err1 = 0;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    logic         p;
    int           k;
    rst = 1'b1; s_valid = 1'b0; s_bit = 1'b0; s_first = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outputs", {m_valid, s_ready, m_data, and_r, or_r, xor_r, parity_err, frame_err},
        {1'b0, 1'b1, {W{1'b0}}, 5'b0});
    chk_counts("reset");

    // Non-first beats in IDLE are dropped
    beat(1'b0, 1'b1);
    chk("idle_drop", m_valid, 0);

    send_frame(4'b0000, 1'b0, 1'b0); handshake(0, 4'b0000);
    send_frame(4'b1111, 1'b0, 1'b0); handshake(0, 4'b1111);
    send_frame(4'b1111, 1'b1, 1'b0); handshake(1, 4'b1111);
    send_frame(4'b0111, 1'b1, 1'b0); handshake(0, 4'b0111);
    send_frame(4'b0111, 1'b0, 1'b0); handshake(0, 4'b0111);

    // Backpressure with s_valid held high
    send_frame(4'b1010, 1'b0, 1'b0);
    s_valid = 1'b1; s_first = 1'b1; s_bit = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_hold", {s_ready, m_valid, m_data, parity_err}, {1'b0, 1'b1, 4'b1010, 1'b0});
    end
    s_valid = 1'b0; s_first = 1'b0; s_bit = 1'b0;
    handshake(0, 4'b1010);

    // Abort after two data bits, then bits 0,1,0 and p=0
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b1);
    send_frame(4'b0101, 1'b0, 1'b1);
    handshake(0, 4'b0101);

    // Reset mid-DATA
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b1);
    do_reset();
    chk("rst_data", {m_valid, s_ready}, 2'b01);
    beat(1'b0, 1'b1);
    chk("rst_data_no_out", m_valid, 0);
    send_frame(4'b0110, 1'b0, 1'b0); handshake(0, 4'b0110);

    // Reset mid-DONE
    send_frame(4'b1001, 1'b1, 1'b0);
    do_reset();
    chk("rst_done", {m_valid, s_ready, m_data, parity_err}, {1'b0, 1'b1, 4'b0000, 1'b0});
    chk_counts("rst_done");
    send_frame(4'b0011, 1'b0, 1'b0); handshake(0, 4'b0011);

    // Randomized frames with occasional aborts and output stalls
    for (int n = 0; n < 40; n++) begin
      w = W'($urandom);
      p = 1'($urandom);
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
      for (int i = 0; i < k; i++) beat(i == 0, 1'($urandom));
      send_frame(w, p, k > 0);
      handshake(int'($urandom_range(0, 3)), w);
    end

`ifdef SERIAL_REDUCTION_STATS_EN
    for (int n = 0; n < 300; n++) begin
      send_frame(4'b0000, 1'b1, 1'b0);
      handshake(0, 4'b0000);
    end
    chk("err_count_sat", err_count, 8'd255);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule

// File: doc/serial_reduction_receiver.md
Name: serial_reduction_receiver

Overview:
- Receiving end of a serial parity-protected word link. The matching transmitter sends WIDTH data bits, LSB first, followed by one parity bit.
- Deserialises the frame and builds the AND, OR and XOR reductions incrementally, one bit per accepted beat.
- Checks the received parity bit and presents the word plus its reductions on a valid/ready output.
- Used as the sink-side checker in the operators/reduction practice designs.

Parameters:
- WIDTH, 4, number of data bits per frame (>=2).
- PARITY_ODD, 0: 0 = even parity (XOR of data and parity bit must be 0); 1 = odd parity (must be 1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- s_valid  input  1  serial bit valid
- s_bit  input  1  serial data/parity bit
- s_first  input  1  qualifies the first data bit of a frame (bit 0)
- s_ready  output  1  receiver can accept a bit
- m_valid  output  1  result word available
- m_ready  input  1  downstream accepts result
- m_data  output  WIDTH  received word
- and_r  output  1  AND reduction of m_data
- or_r  output  1  OR reduction of m_data
- xor_r  output  1  XOR reduction of m_data
- parity_err  output  1  parity mismatch for m_data
- frame_err  output  1  one-cycle pulse: frame aborted by an unexpected s_first

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE and the bit counter clears.
  - m_valid, m_data, and_r, or_r, xor_r, parity_err and frame_err all go to 0.
  - s_ready goes to 1.
  - Reset mid-frame or mid-output discards everything with no output.
- Beat: a bit is accepted only when s_valid && s_ready at the clk edge.
- IDLE:
  - An accepted beat with s_first=1 stores s_bit into bit 0 and seeds the accumulators: and_acc=s_bit, or_acc=s_bit, xor_acc=s_bit.
  - Counter goes to 1 and the state goes to DATA.
  - Accepted beats with s_first=0 are dropped silently.
- DATA:
  - Each accepted beat stores s_bit at index counter and updates the accumulators: and_acc&=s_bit, or_acc|=s_bit, xor_acc^=s_bit.
  - The counter increments.
  - After bit WIDTH-1 is stored, the state goes to PARITY.
- PARITY:
  - The next accepted beat is the parity bit p.
  - parity_err = (xor_acc ^ p) != PARITY_ODD.
  - Outputs are loaded from the accumulators and m_valid=1 on the following edge, i.e. 1-cycle latency from parity beat acceptance. State goes to DONE.
- DONE:
  - s_ready=0.
  - m_valid and all result outputs hold stable until m_valid && m_ready.
  - On that handshake: m_valid=0, state goes to IDLE, s_ready=1 the next cycle. There is no bypass, so at most one frame is in flight.
- Unexpected s_first:
  - An accepted beat with s_first=1 in DATA or PARITY aborts the current frame and pulses frame_err=1 for one cycle.
  - That beat is treated as bit 0 of a new frame: restart as in IDLE, state DATA.
- s_ready is 1 in IDLE, DATA and PARITY, and 0 in DONE.
- Result outputs keep their last values after the handshake. Only m_valid qualifies them.
- Reductions are always consistent with m_data: and_r=&m_data, or_r=|m_data, xor_r=^m_data.

Optional Feature:
- Macro: SERIAL_REDUCTION_STATS_EN.
- Defined:
  - Adds output port err_count (8 bits).
  - err_count is a saturating count of frames delivered with parity_err=1 plus frame_err pulses.
  - Increments by 1 per event and holds at 255.
  - If both events occur in the same cycle it increments once per event, saturating.
  - Clears to 0 on rst.
- Undefined: the port and its counter logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=4, PARITY_ODD=0. Send bits 0,0,0,0 then p=0, m_ready=1 -> m_data=4'b0000, and_r=0, or_r=0, xor_r=0, parity_err=0; m_valid high exactly 1 cycle after the parity beat.
- Send data 4'b1111 (LSB first) then p=0 -> and_r=1, or_r=1, xor_r=0, parity_err=0. Repeat with p=1 -> parity_err=1.
- Send data 4'b0111 then p=1 -> xor_r=1, parity_err=0. Repeat with PARITY_ODD=1 and p=0 -> parity_err=0.
- Backpressure: hold m_ready=0 for 5 cycles after m_valid while driving s_valid=1 -> s_ready=0, outputs stable, no beats accepted. Raise m_ready -> one handshake, s_ready=1 next cycle.
- After 2 data bits, send a beat with s_first=1, s_bit=1 -> frame_err pulses 1 cycle. Completing 3 more bits 0,1,0 + p=0 yields m_data=4'b0101.
- Assert rst for 1 cycle mid-DATA and mid-DONE -> m_valid=0, s_ready=1, no output for the partial frame. The next full frame decodes correctly. With SERIAL_REDUCTION_STATS_EN, 300 bad-parity frames -> err_count=255.
